// File: rtl/vram_line_fetch_arbiter_if.sv
// VRAM line-fetch arbiter bus bundle.
// Timing-gen, CPU, VRAM and line-buffer signals.
interface vram_line_fetch_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              line_start;
  logic [9:0]        line_num;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic              lb_bank;
  logic [7:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              fetch_done;
  logic              underrun;
  logic              underrun_clr;

  modport slave (
    input  line_start, line_num,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output lb_we, lb_bank, lb_addr, lb_wdata,
    output fetch_done, underrun,
    input  underrun_clr
  );

  modport master (
    output line_start, line_num,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  lb_we, lb_bank, lb_addr, lb_wdata,
    input  fetch_done, underrun,
    output underrun_clr
  );
endinterface

// File: rtl/vram_line_fetch_arbiter.sv
// Shares single-port VRAM between scanline prefetch
// and the CPU port with bounded CPU starvation.
module vram_line_fetch_arbiter #(
  parameter int H_WORDS     = 160,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int FETCH_BURST = 8,
  parameter int VRAM_BASE   = 0
) (
  input logic clk,
  input logic reset,
  vram_line_fetch_arbiter_if.slave bus
);

  localparam int BW = $clog2(FETCH_BURST + 1);
  localparam logic [9:0]    VRES_L = 10'(V_RES);
  localparam logic [7:0]    LAST_L = 8'(H_WORDS - 1);
  localparam logic [BW-1:0] BMAX_L = BW'(FETCH_BURST);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic              bank_q;
  logic [7:0]        idx_q;
  logic [BW-1:0]     burst_q;
  logic              ack_q;
  logic              rd_q;
  logic              lbv_q;
  logic              lb_bank_q;
  logic [7:0]        lb_addr_q;
  logic              underrun_q;

  logic              cpu_ok;
  logic              fetch_cyc;
  logic              cpu_gnt;
  logic              fet_gnt;
  logic [ADDR_W-1:0] base_d;

  assign cpu_ok    = bus.cpu_req & ~ack_q;
  assign fetch_cyc = (state_q == FETCH) & ~bus.line_start;
  assign base_d    = ADDR_W'(VRAM_BASE)
                   + ADDR_W'(bus.line_num) * ADDR_W'(H_WORDS);

  // One grant per cycle; CPU wins mid-fetch only after a full burst.
  always_comb begin
    cpu_gnt = 1'b0;
    fet_gnt = 1'b0;
    if (!reset) begin
      if (!fetch_cyc)
        cpu_gnt = cpu_ok;
      else if (cpu_ok && burst_q == BMAX_L)
        cpu_gnt = 1'b1;
      else
        fet_gnt = 1'b1;
    end
  end

  assign bus.mem_en    = cpu_gnt | fet_gnt;
  assign bus.mem_we    = cpu_gnt & bus.cpu_we;
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr :
                         fet_gnt ? base_q + ADDR_W'(idx_q) :
                         '0;
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : '0;

  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_rdata  = rd_q ? bus.mem_rdata : '0;
  assign bus.lb_we      = lbv_q;
  assign bus.lb_bank    = lb_bank_q;
  assign bus.lb_addr    = lb_addr_q;
  assign bus.lb_wdata   = lbv_q ? bus.mem_rdata : '0;
  assign bus.fetch_done = lbv_q & (lb_addr_q == LAST_L);
  assign bus.underrun   = underrun_q;

  // Fetch FSM, burst counter, ack/lb pipelines and underrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      bank_q     <= 1'b0;
      idx_q      <= '0;
      burst_q    <= '0;
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      lbv_q      <= 1'b0;
      lb_bank_q  <= 1'b0;
      lb_addr_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      ack_q <= cpu_gnt;
      rd_q  <= cpu_gnt & ~bus.cpu_we;
      lbv_q <= fet_gnt;
      if (fet_gnt) begin
        lb_addr_q <= idx_q;
        lb_bank_q <= bank_q;
      end
      if (bus.line_start && state_q == FETCH)
        underrun_q <= 1'b1;
      else if (bus.underrun_clr)
        underrun_q <= 1'b0;
      if (bus.line_start) begin
        if (bus.line_num < VRES_L) begin
          state_q <= FETCH;
          base_q  <= base_d;
          bank_q  <= bus.line_num[0];
          idx_q   <= '0;
          burst_q <= '0;
        end else begin
          state_q <= IDLE;
        end
      end else if (fet_gnt) begin
        idx_q <= idx_q + 8'd1;
        if (burst_q != BMAX_L)
          burst_q <= burst_q + BW'(1);
        if (idx_q == LAST_L)
          state_q <= IDLE;
      end else if (cpu_gnt && state_q == FETCH) begin
        burst_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_line_fetch_arbiter.sv
// Self-checking bench for vram_line_fetch_arbiter.
// Per-cycle log plus rule-level checks of each line.
module tb_vram_line_fetch_arbiter;
  localparam int N = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  vram_line_fetch_arbiter_if bus ();

  vram_line_fetch_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] vram [int];
  logic [31:0] refm [int];

  function automatic logic [31:0] pat(input int a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] vread(input int a);
    if (vram.exists(a)) return vram[a];
    return pat(a);
  endfunction

  function automatic int ix(input int c);
    return c % N;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      if (bus.mem_we)
        vram[int'(bus.mem_addr)] = bus.mem_wdata;
      else
        bus.mem_rdata <= vread(int'(bus.mem_addr));
    end
  end

  logic        g_en   [N];
  logic        g_we   [N];
  logic [16:0] g_addr [N];
  logic [31:0] g_wd   [N];
  logic        l_we   [N];
  logic        l_bank [N];
  logic [7:0]  l_addr [N];
  logic [31:0] l_data [N];
  logic        l_done [N];
  logic        a_ack  [N];
  logic [31:0] a_rd   [N];
  logic        c_wait [N];

  always @(negedge clk) begin
    int k;
    k = ix(cyc);
    g_en[k]   = bus.mem_en;
    g_we[k]   = bus.mem_we;
    g_addr[k] = bus.mem_addr;
    g_wd[k]   = bus.mem_wdata;
    l_we[k]   = bus.lb_we;
    l_bank[k] = bus.lb_bank;
    l_addr[k] = bus.lb_addr;
    l_data[k] = bus.lb_wdata;
    l_done[k] = bus.fetch_done;
    a_ack[k]  = bus.cpu_ack;
    a_rd[k]   = bus.cpu_rdata;
    c_wait[k] = bus.cpu_req & ~bus.cpu_ack;
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {bus.mem_en, bus.mem_we, bus.cpu_ack,
        bus.lb_we, bus.lb_bank, bus.fetch_done, bus.underrun}, 0);
    chk({tag, "_lba"}, bus.lb_addr, 0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 0);
    chk({tag, "_dat"}, {bus.cpu_rdata, bus.lb_wdata}, 0);
  endtask

  // Walks the log from line_start cycle t0 and checks every word of
  // the line: address order, lb write one cycle later, no idle cycle
  // while fetching, and CPU granted exactly when it waited a full burst.
  task automatic check_line(input string tag, input int t0,
                            input int line, output int tl);
    int base;
    int k;
    int run;
    int c;
    base = line * 160;
    k = 0;
    run = 0;
    c = t0 + 1;
    tl = t0;
    chk({tag, "_start"}, g_en[ix(t0)] && !a_ack[ix(t0 + 1)], 1'b0);
    while (k < 160 && c <= t0 + 400) begin
      chk({tag, "_busy"}, g_en[ix(c)], 1'b1);
      if (g_en[ix(c)] && a_ack[ix(c + 1)]) begin
        chk({tag, "_cpu_early"}, run, 8);
        run = 0;
      end else if (g_en[ix(c)]) begin
        chk({tag, "_starve"}, c_wait[ix(c)] && run >= 8, 1'b0);
        chk({tag, "_addr"}, {g_we[ix(c)], g_addr[ix(c)]},
            {1'b0, 17'(base + k)});
        chk({tag, "_lb"}, {l_we[ix(c + 1)], l_bank[ix(c + 1)],
            l_addr[ix(c + 1)], l_done[ix(c + 1)]},
            {1'b1, line[0], 8'(k), k == 159});
        chk({tag, "_lbdata"}, l_data[ix(c + 1)], vread(base + k));
        k++;
        run = (run >= 8) ? 8 : run + 1;
        tl = c;
      end
      c++;
    end
    chk({tag, "_words"}, k, 160);
    chk({tag, "_end"}, l_we[ix(tl + 2)], 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tl, w, s, n, line, wcnt, p_addr;
    logic p_we;
    logic [31:0] p_wd;

    bus.line_start = 1'b0;
    bus.line_num = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.underrun_clr = 1'b0;
    wcnt = 0;
    p_we = 1'b0;
    p_addr = 0;
    p_wd = '0;

    tick(3);
    check_zero("rst_hold");
    reset = 1'b0;
    tick(2);
    check_zero("rst_idle");

    // Idle fetch of line 3.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd3;
    tick(1);
    bus.line_start = 1'b0;
    tick(175);
    check_line("A", t0, 3, tl);
    chk("A_first_addr", g_addr[ix(t0 + 1)], 17'd480);
    chk("A_len", tl - t0, 160);

    // CPU write then read while idle.
    t0 = cyc;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 17'h00100;
    bus.cpu_wdata = 32'hDEADBEEF;
    w = 0;
    do begin tick(1); w++; end while (!bus.cpu_ack && w < 10);
    chk("B_wr_lat", w, 1);
    chk("B_wr_rdata", bus.cpu_rdata, 0);
    chk("B_wr_grant", {g_en[ix(t0)], g_we[ix(t0)], g_addr[ix(t0)],
        g_wd[ix(t0)]}, {1'b1, 1'b1, 17'h00100, 32'hDEADBEEF});
    bus.cpu_we = 1'b0;
    w = 0;
    do begin tick(1); w++; end while (!bus.cpu_ack && w < 10);
    chk("B_rd_lat", w, 2);
    chk("B_rd_data", bus.cpu_rdata, 32'hDEADBEEF);
    bus.cpu_req = 1'b0;
    tick(2);
    s = 0;
    for (int c = t0; c < cyc; c++) s += int'(l_we[ix(c)]);
    chk("B_no_lb", s, 0);

    // Line 5 fetch with a CPU read request held throughout.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd5;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 17'h1F000;
    tick(1);
    bus.line_start = 1'b0;
    tick(185);
    bus.cpu_req = 1'b0;
    tick(3);
    check_line("C", t0, 5, tl);
    chk("C_len", tl + 1 - t0, 180);
    n = 0;
    for (int c = t0 + 1; c <= t0 + 180; c++) begin
      if (a_ack[ix(c)]) begin
        n++;
        chk("C_rdata", a_rd[ix(c)], vread(32'h1F000));
        chk("C_ack_grant", g_addr[ix(c - 1)], 17'h1F000);
      end
    end
    chk("C_acks", n, 20);

    // Underrun: line 8 arrives 50 cycles into line 7, clear coincides.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd7;
    tick(1);
    bus.line_start = 1'b0;
    tick(49);
    bus.line_start = 1'b1;
    bus.line_num = 10'd8;
    bus.underrun_clr = 1'b1;
    tick(1);
    bus.line_start = 1'b0;
    bus.underrun_clr = 1'b0;
    chk("D_set_wins", bus.underrun, 1'b1);
    tick(170);
    chk("D_inflight", {l_we[ix(t0 + 50)], l_bank[ix(t0 + 50)],
        l_addr[ix(t0 + 50)]}, {1'b1, 1'b1, 8'd48});
    check_line("D", t0 + 50, 8, tl);
    chk("D_restart_addr", g_addr[ix(t0 + 51)], 17'd1280);
    chk("D_hold", bus.underrun, 1'b1);
    bus.underrun_clr = 1'b1;
    tick(1);
    bus.underrun_clr = 1'b0;
    chk("D_cleared", bus.underrun, 1'b0);

    // Out-of-range line while idle.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd480;
    tick(1);
    bus.line_start = 1'b0;
    tick(20);
    s = 0;
    for (int c = t0; c <= t0 + 20; c++)
      s += int'(g_en[ix(c)]) + int'(l_we[ix(c)]);
    chk("E_no_fetch", s, 0);
    chk("E_no_underrun", bus.underrun, 1'b0);

    // Out-of-range line mid-fetch of line 2.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd2;
    tick(1);
    bus.line_start = 1'b0;
    tick(9);
    bus.line_start = 1'b1;
    bus.line_num = 10'd600;
    tick(1);
    bus.line_start = 1'b0;
    tick(10);
    chk("E2_underrun", bus.underrun, 1'b1);
    chk("E2_inflight", {l_we[ix(t0 + 10)], l_bank[ix(t0 + 10)],
        l_addr[ix(t0 + 10)]}, {1'b1, 1'b0, 8'd8});
    s = 0;
    for (int c = t0 + 10; c <= t0 + 20; c++)
      s += int'(g_en[ix(c)]) + int'(l_we[ix(c + 1)]);
    chk("E2_stopped", s, 0);
    bus.underrun_clr = 1'b1;
    tick(1);
    bus.underrun_clr = 1'b0;

    // Reset 20 cycles into a fetch of line 1.
    t0 = cyc;
    bus.line_start = 1'b1;
    bus.line_num = 10'd1;
    tick(1);
    bus.line_start = 1'b0;
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_zero("F_after");
    tick(15);
    s = 0;
    for (int c = t0 + 21; c <= t0 + 35; c++)
      s += int'(g_en[ix(c)]) + int'(l_we[ix(c)]) + int'(a_ack[ix(c)]);
    chk("F_quiet", s, 0);

    // Random CPU traffic against random lines.
    for (int it = 0; it < 3; it++) begin
      line = $urandom_range(0, 479);
      t0 = cyc;
      bus.line_start = 1'b1;
      bus.line_num = 10'(line);
      for (int k = 0; k < 220; k++) begin
        if (bus.cpu_req && bus.cpu_ack) begin
          if (p_we) begin
            chk("R_wack", bus.cpu_rdata, 0);
            refm[p_addr] = p_wd;
          end else begin
            chk("R_rdata", bus.cpu_rdata,
                refm.exists(p_addr) ? refm[p_addr] : pat(p_addr));
          end
          bus.cpu_req = 1'b0;
        end else if (bus.cpu_req) begin
          wcnt++;
          if (wcnt == 40) begin
            chk("R_cpu_timeout", bus.cpu_ack, 1'b1);
            bus.cpu_req = 1'b0;
          end
        end
        if (!bus.cpu_req && k < 200 && $urandom_range(0, 2) != 0) begin
          p_we = 1'($urandom_range(0, 1));
          p_addr = 32'h1F000 + int'($urandom_range(0, 15));
          p_wd = $urandom;
          wcnt = 0;
          bus.cpu_req = 1'b1;
          bus.cpu_we = p_we;
          bus.cpu_addr = 17'(p_addr);
          bus.cpu_wdata = p_wd;
        end
        tick(1);
        bus.line_start = 1'b0;
      end
      bus.cpu_req = 1'b0;
      tick(2);
      check_line("R", t0, line, tl);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/vram_line_fetch_arbiter.md
Name: vram_line_fetch_arbiter

Overview:
- Shares the single-port video RAM between two requesters: the scanline prefetch engine that fills the double-buffered line buffer feeding the VGA pixel pipeline, and the CPU bus port.
- On each line_start pulse from the VGA timing generator, the block fetches one scanline of H_WORDS words into the idle line-buffer bank.
- CPU accesses are interleaved with the fetch using a bounded-starvation rule.
- Sits between the VGA timing generator, the line buffer and the CPU interconnect.

Parameters:
- H_WORDS, 160, words per scanline (640 px at 4 px per 32-bit word).
- V_RES, 480, visible lines; a line_num >= V_RES starts no fetch.
- ADDR_W, 17, VRAM word-address width.
- DATA_W, 32, VRAM data width.
- FETCH_BURST, 8, maximum consecutive fetch grants before a waiting CPU request is granted.
- VRAM_BASE, 0, word address of line 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- line_start  in  1  single-cycle pulse requesting a fetch of line_num.
- line_num  in  10  line to fetch, sampled when line_start=1.
- cpu_req  in  1  CPU request, held until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
- mem_en  out  1  VRAM access this cycle.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after a read.
- lb_we  out  1  line-buffer write strobe.
- lb_bank  out  1  line-buffer bank for this write (= latched line_num[0]).
- lb_addr  out  8  word index within the line.
- lb_wdata  out  DATA_W  line-buffer write data.
- fetch_done  out  1  pulses together with the final lb_we of a line.
- underrun  out  1  sticky flag; a new line_start arrived before the previous fetch finished.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; any pending ack or lb write pipeline entry is discarded. Reset mid-fetch abandons the line; underrun is not set.
- Fetch FSM, IDLE -> FETCH:
  - Triggered by line_start with line_num < V_RES.
  - Latches base = VRAM_BASE + line_num*H_WORDS, bank = line_num[0], word index = 0, burst_cnt = 0.
  - No fetch grant is issued in the line_start cycle; the CPU may be granted in that cycle.
- FETCH -> IDLE: after the grant of word H_WORDS-1.
- line_start while in FETCH:
  - Sets underrun (also with line_num >= V_RES).
  - Abandons the remaining words of the current line.
  - Reloads for the new line, or goes to IDLE if line_num >= V_RES.
  - An lb write already in the pipeline completes with its original bank/addr.
- Arbiter, evaluated every cycle, all mem_* driven combinationally:
  - cpu_ok = cpu_req & ~cpu_ack, so an acked request is not regranted in its ack cycle.
  - IDLE: grant the CPU if cpu_ok.
  - FETCH, excluding the line_start cycle: grant the CPU if cpu_ok and burst_cnt == FETCH_BURST, then set burst_cnt = 0. Otherwise grant fetch and increment burst_cnt, saturating at FETCH_BURST.
  - At most one grant per cycle. mem_en=0 when there is no grant.
- Fetch grant:
  - mem_we=0, mem_addr=base+index, index increments.
  - Next cycle: lb_we=1, lb_addr=granted index, lb_wdata=mem_rdata, lb_bank=latched bank.
- CPU grant:
  - mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Next cycle: cpu_ack=1; cpu_rdata=mem_rdata for reads, 0 for writes.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- fetch_done = lb_we & (lb_addr == H_WORDS-1).
- underrun: set has priority over underrun_clr when both occur in the same cycle.
- Worst-case fetch length with a continuously requesting CPU: H_WORDS + ceil(H_WORDS/FETCH_BURST) cycles = 180 at defaults. This fits in horizontal blanking plus the preceding active line.

Test Plan:
- Idle line fetch: line_start, line_num=3, no CPU traffic.
  - mem_addr 480..639 on consecutive cycles.
  - lb_we for 160 cycles, lb_bank=1, lb_addr 0..159.
  - fetch_done coincides with lb_addr=159.
- Contention: cpu_req held during a line-5 fetch, with repeated reads to address 0x1F000.
  - CPU granted after every 8 fetch grants; each cpu_ack one cycle after its grant.
  - Line completes 180 cycles after start.
- CPU write then read while idle: write 0xDEADBEEF to 0x00100, then read 0x00100.
  - Two acks, each one cycle after its grant; read returns 0xDEADBEEF; no lb_we.
- Underrun: second line_start (line 8) 50 cycles into a line-7 fetch.
  - underrun=1; the in-flight lb write completes with bank 1.
  - The fetch restarts at address 1280 with bank 0.
  - underrun_clr later clears the flag.
- line_start with line_num=480: no fetch, no lb_we, state remains IDLE.
- Reset asserted 20 cycles into a fetch: next cycle all outputs are 0; no lb_we or cpu_ack follows.
